// File: rtl/lfsr_gen.sv
// Parameterisable Fibonacci/Galois LFSR with all-zero lockup recovery
// and measurement of the period of the sequence it is running.
module lfsr_gen #(
    parameter int              WIDTH        = 8,
    parameter logic [WIDTH-1:0] TAPS        = 8'hB8,
    parameter int              MODE         = 0,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             enable,
    output logic [WIDTH-1:0] result,
    output logic             lockup,
    output logic             period_done,
    output logic [WIDTH-1:0] period
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t           r_state,       w_state_nxt;
    logic [WIDTH-1:0] r_result,      w_result_nxt;
    logic [WIDTH-1:0] r_start,       w_start_nxt;
    logic [WIDTH-1:0] r_step_cnt,    w_step_cnt_nxt;
    logic [WIDTH-1:0] r_period,      w_period_nxt;
    logic             r_period_done, w_period_done_nxt;

    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_cnt_inc;

    always_comb begin
        if (MODE == 0) begin
            w_step = {r_result[WIDTH-2:0], ^(r_result & TAPS)};
        end else begin
            w_step = (r_result << 1) ^ (r_result[WIDTH-1] ? TAPS : '0);
        end
    end

    assign w_cnt_inc = (r_step_cnt == '1) ? r_step_cnt : r_step_cnt + WIDTH'(1);

    always_comb begin
        // NOTE: every next-state value gets a default first so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        w_result_nxt      = r_result;
        w_start_nxt       = r_start;
        w_step_cnt_nxt    = r_step_cnt;
        w_period_nxt      = r_period;
        w_period_done_nxt = 1'b0;

        if (load) begin
            w_result_nxt = seed;
            if (seed != '0) begin
                w_start_nxt    = seed;
                w_step_cnt_nxt = '0;
            end
        end else if (enable) begin
            if (r_state == ST_LOCK) begin
                w_result_nxt   = DEFAULT_SEED;
                w_start_nxt    = DEFAULT_SEED;
                w_step_cnt_nxt = '0;
            end else begin
                w_result_nxt = w_step;
                if (w_step == r_start) begin
                    w_period_done_nxt = 1'b1;
                    w_period_nxt      = w_cnt_inc;
                    w_step_cnt_nxt    = '0;
                end else begin
                    w_step_cnt_nxt = w_cnt_inc;
                end
            end
        end

        // LOCK tracks the register contents, so a bad tap mask that steps
        // into zero is also caught and recovered.
        w_state_nxt = (w_result_nxt == '0) ? ST_LOCK : ST_RUN;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_result      <= DEFAULT_SEED;
            r_start       <= DEFAULT_SEED;
            r_step_cnt    <= '0;
            r_period      <= '0;
            r_period_done <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_result      <= w_result_nxt;
            r_start       <= w_start_nxt;
            r_step_cnt    <= w_step_cnt_nxt;
            r_period      <= w_period_nxt;
            r_period_done <= w_period_done_nxt;
        end
    end

    assign result      = r_result;
    assign lockup      = (r_state == ST_LOCK);
    assign period_done = r_period_done;
    assign period      = r_period;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: three 4-bit instances (Fibonacci maximal, Galois maximal,
// Fibonacci non-maximal) driven in lockstep and compared to a behavioural model.
module tb_lfsr_gen;

    localparam int N_DUT = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [3:0] seed = 4'h0;
    logic       enable = 1'b0;

    logic [3:0] res [N_DUT];
    logic       lck [N_DUT];
    logic       pdn [N_DUT];
    logic [3:0] per [N_DUT];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .MODE(0), .DEFAULT_SEED(4'b0001)) u_fib (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .enable(enable),
        .result(res[0]), .lockup(lck[0]), .period_done(pdn[0]), .period(per[0]));

    lfsr_gen #(.WIDTH(4), .TAPS(4'b0011), .MODE(1), .DEFAULT_SEED(4'b0001)) u_gal (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .enable(enable),
        .result(res[1]), .lockup(lck[1]), .period_done(pdn[1]), .period(per[1]));

    lfsr_gen #(.WIDTH(4), .TAPS(4'b1111), .MODE(0), .DEFAULT_SEED(4'b0001)) u_nm (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .enable(enable),
        .result(res[2]), .lockup(lck[2]), .period_done(pdn[2]), .period(per[2]));

    typedef struct {
        int result;
        int start;
        int cnt;
        int period;
        int pd;
    } model_t;

    model_t mdl [N_DUT];

    // Sequence step as polynomial arithmetic on integers.
    function automatic int lfsr_next(input int idx, input int x);
        int taps;
        int v;
        taps = (idx == 0) ? 12 : (idx == 1) ? 3 : 15;
        if (idx == 1) begin
            v = x * 2;
            if (v >= 16) v = (v - 16) ^ taps;
        end else begin
            v = ((x * 2) % 16) + ($countones(x & taps) % 2);
        end
        return v;
    endfunction

    function automatic model_t model_next(input model_t m, input int idx, input bit rst,
                                          input bit ld, input int sd, input bit en);
        model_t n;
        int nx;
        n = m;
        n.pd = 0;
        if (rst) begin
            n.result = 1; n.start = 1; n.cnt = 0; n.period = 0;
        end else if (ld) begin
            n.result = sd;
            if (sd != 0) begin
                n.start = sd; n.cnt = 0;
            end
        end else if (en) begin
            if (m.result == 0) begin
                n.result = 1; n.start = 1; n.cnt = 0;
            end else begin
                nx = lfsr_next(idx, m.result);
                n.result = nx;
                if (nx == m.start) begin
                    n.pd = 1;
                    n.period = (m.cnt + 1 > 15) ? 15 : m.cnt + 1;
                    n.cnt = 0;
                end else begin
                    n.cnt = (m.cnt + 1 > 15) ? 15 : m.cnt + 1;
                end
            end
        end
        return n;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step(input bit rst, input bit ld, input logic [3:0] sd, input bit en);
        @(negedge clk);
        reset  = rst;
        load   = ld;
        seed   = sd;
        enable = en;
        @(posedge clk);
        for (int k = 0; k < N_DUT; k++) mdl[k] = model_next(mdl[k], k, rst, ld, int'(sd), en);
        #1;
        for (int k = 0; k < N_DUT; k++) begin
            check($sformatf("model result[%0d]", k), int'(res[k]), mdl[k].result);
            check($sformatf("model lockup[%0d]", k), int'(lck[k]), (mdl[k].result == 0) ? 1 : 0);
            check($sformatf("model period_done[%0d]", k), int'(pdn[k]), mdl[k].pd);
            check($sformatf("model period[%0d]", k), int'(per[k]), mdl[k].period);
        end
    endtask

    typedef struct {
        bit       rst;
        bit       ld;
        bit [3:0] sd;
        bit       en;
        bit [3:0] exp_result;
        bit       exp_lockup;
        bit       exp_pd;
        bit [3:0] exp_period;
    } vec_t;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       vecs [18];
        logic [3:0] gal_exp [4];

        for (int k = 0; k < N_DUT; k++) mdl[k] = '{0, 0, 0, 0, 0};

        // Directed table on the Fibonacci instance.
        vecs[0]  = '{1, 0, 4'h0, 0, 4'b0001, 0, 0, 4'd0};
        vecs[1]  = '{0, 0, 4'h0, 1, 4'b0010, 0, 0, 4'd0};
        vecs[2]  = '{0, 0, 4'h0, 1, 4'b0100, 0, 0, 4'd0};
        vecs[3]  = '{0, 0, 4'h0, 1, 4'b1001, 0, 0, 4'd0};
        vecs[4]  = '{0, 0, 4'h0, 1, 4'b0011, 0, 0, 4'd0};
        vecs[5]  = '{0, 0, 4'h0, 1, 4'b0110, 0, 0, 4'd0};
        vecs[6]  = '{0, 0, 4'h0, 1, 4'b1101, 0, 0, 4'd0};
        vecs[7]  = '{0, 1, 4'h0, 0, 4'b0000, 1, 0, 4'd0};
        vecs[8]  = '{0, 0, 4'h0, 0, 4'b0000, 1, 0, 4'd0};
        vecs[9]  = '{0, 0, 4'h0, 1, 4'b0001, 0, 0, 4'd0};
        vecs[10] = '{0, 0, 4'h0, 1, 4'b0010, 0, 0, 4'd0};
        vecs[11] = '{0, 1, 4'h9, 1, 4'b1001, 0, 0, 4'd0};
        vecs[12] = '{0, 0, 4'h0, 1, 4'b0011, 0, 0, 4'd0};
        vecs[13] = '{0, 0, 4'h0, 1, 4'b0110, 0, 0, 4'd0};
        vecs[14] = '{1, 1, 4'h6, 1, 4'b0001, 0, 0, 4'd0};
        vecs[15] = '{0, 1, 4'h0, 1, 4'b0000, 1, 0, 4'd0};
        vecs[16] = '{0, 1, 4'h5, 1, 4'b0101, 0, 0, 4'd0};
        vecs[17] = '{1, 0, 4'h0, 0, 4'b0001, 0, 0, 4'd0};

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].rst, vecs[i].ld, vecs[i].sd, vecs[i].en);
            check($sformatf("vec%0d result", i), int'(res[0]), int'(vecs[i].exp_result));
            check($sformatf("vec%0d lockup", i), int'(lck[0]), int'(vecs[i].exp_lockup));
            check($sformatf("vec%0d period_done", i), int'(pdn[0]), int'(vecs[i].exp_pd));
            check($sformatf("vec%0d period", i), int'(per[0]), int'(vecs[i].exp_period));
        end

        // Full period from reset: Fibonacci and Galois both 15, non-maximal 5.
        gal_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0011};
        step(1, 0, 4'h0, 0);
        for (int s = 1; s <= 15; s++) begin
            step(0, 0, 4'h0, 1);
            if (s <= 4) check($sformatf("galois step%0d", s), int'(res[1]), int'(gal_exp[s-1]));
            if (s == 5) begin
                check("nonmax period_done", int'(pdn[2]), 1);
                check("nonmax period", int'(per[2]), 5);
            end
            if (s < 15) check($sformatf("fib no pulse step%0d", s), int'(pdn[0]), 0);
        end
        check("fib wrap result", int'(res[0]), 1);
        check("fib wrap period_done", int'(pdn[0]), 1);
        check("fib wrap period", int'(per[0]), 15);
        check("galois wrap period", int'(per[1]), 15);
        step(0, 0, 4'h0, 1);
        check("fib pulse one cycle", int'(pdn[0]), 0);
        check("fib period holds", int'(per[0]), 15);

        // Seeded run from 1001; load keeps the previous period.
        step(0, 1, 4'h9, 0);
        check("load keeps period", int'(per[0]), 15);
        for (int s = 1; s <= 15; s++) begin
            step(0, 0, 4'h0, 1);
            if (s == 1) check("seed step1", int'(res[0]), 4'b0011);
            if (s == 2) check("seed step2", int'(res[0]), 4'b0110);
        end
        check("seed wrap result", int'(res[0]), 4'b1001);
        check("seed wrap period_done", int'(pdn[0]), 1);
        check("seed wrap period", int'(per[0]), 15);

        // Load on the edge that would otherwise wrap suppresses the pulse.
        step(0, 1, 4'h9, 0);
        repeat (14) step(0, 0, 4'h0, 1);
        step(0, 1, 4'h9, 1);
        check("load at wrap result", int'(res[0]), 4'b1001);
        check("load at wrap no pulse", int'(pdn[0]), 0);

        // Reset mid-sequence with load asserted.
        step(0, 0, 4'h0, 0);
        repeat (7) step(0, 0, 4'h0, 1);
        step(1, 1, 4'hA, 1);
        check("reset over load result", int'(res[0]), 1);
        check("reset clears period", int'(per[0]), 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
                 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 8: register width, legal range 3..32.
REQ-002 Parameter TAPS, default 8'hB8: WIDTH-bit feedback tap mask.
REQ-003 Parameter MODE, default 0: 0 = Fibonacci, 1 = Galois.
REQ-004 Parameter DEFAULT_SEED, default 1: nonzero WIDTH-bit value used at reset and on lockup recovery.
REQ-005 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-006 Port reset  input  1: synchronous, active-high reset.
REQ-007 Port load  input  1: when high, seed is loaded on the next edge.
REQ-008 Port seed  input  WIDTH: value to load.
REQ-009 Port enable  input  1: advance the register one step per cycle while high.
REQ-010 Port result  output  WIDTH: current register state.
REQ-011 Port lockup  output  1: high while the register holds all zeros.
REQ-012 Port period_done  output  1: one-cycle pulse when the sequence returns to its start value.
REQ-013 Port period  output  WIDTH: step count of the last completed cycle.

Function
REQ-014 Fibonacci step: next = {result[WIDTH-2:0], ^(result & TAPS)}; bit 0 takes the feedback, bit i takes bit i-1.
REQ-015 Galois step: next = (result << 1) ^ (result[WIDTH-1] ? TAPS : 0); TAPS bit 0 must be 1 in this mode.
REQ-016 Input priority per edge: reset > load > enable; otherwise the register holds.
REQ-017 FSM states: RUN and LOCK; the FSM is in LOCK exactly when result == 0.
REQ-018 load with a nonzero seed: result = seed, state RUN, start = seed, step_cnt = 0.
REQ-019 load with seed == 0: result = 0, state LOCK, lockup = 1 from the next cycle.
REQ-020 In LOCK, enable does not shift; the first enabled edge loads DEFAULT_SEED, returns to RUN, sets start = DEFAULT_SEED, clears step_cnt.
REQ-021 In LOCK, load takes priority over recovery.
REQ-022 In RUN with enable: result advances once; step_cnt increments and saturates at all-ones.
REQ-023 In RUN with enable, if the next value equals start: the edge pulses period_done high for one cycle, sets period = step_cnt+1 (saturating), and clears step_cnt.
REQ-024 period holds its value until the next period_done; load does not clear it.
REQ-025 A load on the same edge as a would-be wrap suppresses period_done.
REQ-026 A nonmaximal TAPS produces its shorter period with no error; the period output reflects it.
REQ-027 Latency: result reflects load, seed or step one cycle after the qualifying edge; no combinational input-to-output paths.

Reset
REQ-028 On reset: result = DEFAULT_SEED, state RUN, start = DEFAULT_SEED, step_cnt = 0, period = 0, period_done = 0, lockup = 0.
REQ-029 Reset asserted mid-sequence or in LOCK behaves identically to REQ-028 and overrides simultaneous load and enable.

Verification (WIDTH=4, TAPS=4'b1100, MODE=0, DEFAULT_SEED=4'b0001)
REQ-030 Reset, then enable held high: result = 0001, 0010, 0100, 1001, 0011, 0110, 1101, ...; period_done pulses on the 15th step with period = 15.
REQ-031 load seed 0000: lockup = 1 and result holds 0000 on the load; next enabled edge gives result = 0001, lockup = 0.
REQ-032 load seed 1001 with enable held: the next steps are 0011 then 0110; the 15th step returns to 1001 with period_done = 1 and period = 15.
REQ-033 load and enable high on the same edge: result = seed, with no step taken.
REQ-034 Reset asserted at step 7 together with load = 1: result = 0001; period stays at its post-reset value of 0.
REQ-035 MODE=1, TAPS=4'b0011, seed 0001: sequence 0010, 0100, 1000, 0011, ...; period = 15.
